// File: rtl/transmit_ordered_set.sv
// rtl/transmit_ordered_set.sv - 1000BASE-X transmit ordered-set selection FSM
module transmit_ordered_set #(
  parameter int OCTET_WIDTH    = 8,
  parameter int TX_O_SET_WIDTH = 5
) (
  input  logic                      gtx_clk,
  input  logic                      mr_main_reset,
  input  logic                      tx_en,
  input  logic                      tx_er,
  input  logic [OCTET_WIDTH-1:0]    gmii_txd,
  input  logic                      tx_even,
  input  logic                      tx_oset_indicate,
  output logic [TX_O_SET_WIDTH-1:0] tx_o_set,
  output logic [OCTET_WIDTH-1:0]    txd,
  output logic                      transmitting
);

  localparam logic [TX_O_SET_WIDTH-1:0] D_OS = TX_O_SET_WIDTH'(0);
  localparam logic [TX_O_SET_WIDTH-1:0] I_OS = TX_O_SET_WIDTH'(1);
  localparam logic [TX_O_SET_WIDTH-1:0] S_OS = TX_O_SET_WIDTH'(2);
  localparam logic [TX_O_SET_WIDTH-1:0] T_OS = TX_O_SET_WIDTH'(3);
  localparam logic [TX_O_SET_WIDTH-1:0] R_OS = TX_O_SET_WIDTH'(4);
  localparam logic [TX_O_SET_WIDTH-1:0] V_OS = TX_O_SET_WIDTH'(5);

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    START_OF_PACKET = 4'd1,
    START_ERROR     = 4'd2,
    TX_DATA         = 4'd3,
    TX_DATA_ERROR   = 4'd4,
    EOP_NOEXT       = 4'd5,
    EPD2_NOEXT      = 4'd6,
    EPD3            = 4'd7,
    EOP_EXT         = 4'd8,
    CARRIER_EXTEND  = 4'd9,
    EXTEND_BY_1     = 4'd10
  } state_t;

  state_t state;
  state_t nxt;
  logic   state_legal;

  // Decision taken after /S/, /V/ and /D/: continue data, flag error, or end the frame.
  function automatic state_t pkt_state(input logic en, input logic er);
    case ({en, er})
      2'b10:   return TX_DATA;
      2'b11:   return TX_DATA_ERROR;
      2'b01:   return EOP_EXT;
      default: return EOP_NOEXT;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic en,
                                        input logic er, input logic even);
    case (s)
      IDLE: begin
        if (en && !er)     return START_OF_PACKET;
        else if (en && er) return START_ERROR;
        else               return IDLE;
      end
      START_OF_PACKET,
      START_ERROR,
      TX_DATA,
      TX_DATA_ERROR:       return pkt_state(en, er);
      EOP_NOEXT:           return EPD2_NOEXT;
      // A second /R/ when the first lands on an even slot keeps /I/ even-aligned.
      EPD2_NOEXT:          return even ? EPD3 : IDLE;
      EPD3:                return IDLE;
      EOP_EXT:             return (!en && er) ? CARRIER_EXTEND : EXTEND_BY_1;
      CARRIER_EXTEND: begin
        case ({en, er})
          2'b01:   return CARRIER_EXTEND;
          2'b00:   return EXTEND_BY_1;
          2'b10:   return START_OF_PACKET;
          default: return START_ERROR;
        endcase
      end
      EXTEND_BY_1:         return EPD2_NOEXT;
      default:             return IDLE;
    endcase
  endfunction

  function automatic logic [TX_O_SET_WIDTH-1:0] os_of(input state_t s);
    case (s)
      IDLE:                       return I_OS;
      START_OF_PACKET:            return S_OS;
      START_ERROR, TX_DATA_ERROR: return V_OS;
      TX_DATA:                    return D_OS;
      EOP_NOEXT, EOP_EXT:         return T_OS;
      default:                    return R_OS;
    endcase
  endfunction

  assign state_legal = (state <= EXTEND_BY_1);

  always_comb begin
    nxt = next_state(state, tx_en, tx_er, tx_even);
  end

  always_ff @(posedge gtx_clk) begin
    if (mr_main_reset || !state_legal) begin
      state        <= IDLE;
      tx_o_set     <= I_OS;
      txd          <= '0;
      transmitting <= 1'b0;
    end else if (tx_oset_indicate) begin
      state        <= nxt;
      tx_o_set     <= os_of(nxt);
      txd          <= (nxt == TX_DATA) ? gmii_txd : '0;
      transmitting <= (nxt != IDLE);
    end
  end

endmodule
